// File: rtl/mem_bus_pkg.sv
`timescale 1ns/1ps
// mem_bus_pkg
// Shared definitions for the word-copy DMA engine and its helpers.
//   dma_state_e  : engine state encoding (IDLE, RD, WR, FIN)
//   WSTRB_WORD   : byte strobes for a full 32-bit word write
//   WSTRB_READ   : byte strobes for a read (no bytes written)
//   word_offset  : byte offset of word index i (i*4, wraps at 2^32)
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

  function automatic logic [31:0] word_offset(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
`timescale 1ns/1ps
// mem_bus_timeout
// Counts consecutive bus wait cycles and flags the last allowed one.
//   cpu_clk  in  clock
//   reset    in  asynchronous active-high reset
//   clear    in  restart the count (no request outstanding)
//   enable   in  a request is waiting this cycle
//   expired  out this is the TIMEOUT_CYCLES-th waiting cycle; the owner
//                must drop the request on the coming edge
module mem_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic cpu_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of wait cycles already completed, so the
  // comparison against TIMEOUT_CYCLES-1 marks the final allowed cycle.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_dma.sv
`timescale 1ns/1ps
// mem_bus_dma
// Word-granular DMA engine on a picorv32-style native memory bus. Copies
// len_words 32-bit words from src_addr to dst_addr, one read then one
// write per word, with a per-transaction wait timeout.
// Optional feature: define DMA_FILL_EN to allow fill_mode, which skips the
// reads and writes fill_value to every destination word.
//   cpu_clk, reset            clock, asynchronous active-high reset
//   start, src_addr, dst_addr,
//   len_words, fill_mode,
//   fill_value                job request, parameters latched at start
//   busy, done, error,
//   words_done                job status
//   mem_valid, mem_addr,
//   mem_wdata, mem_wstrb,
//   mem_ready, mem_rdata      bus initiator
module mem_bus_dma
  import mem_bus_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             fill_mode,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             armed_q, done_q, error_q, fill_q;
  logic             accept, hs, expired, last_word;
  logic             fill_start;
  logic [31:0]      fill_word, word_off;

`ifdef DMA_FILL_EN
  assign fill_start = fill_mode;
  assign fill_word  = fill_value;
`else
  logic unused_fill;
  assign fill_start  = 1'b0;
  assign fill_word   = 32'h0;
  assign unused_fill = ^{fill_mode, fill_value};
`endif

  assign accept    = start && (state_q == IDLE);
  assign hs        = mem_valid && mem_ready;
  assign last_word = (cnt_q + LEN_W'(1)) == len_q;
  assign word_off  = word_offset(32'(cnt_q));

  mem_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .clear   (!mem_valid),
    .enable  (mem_valid && !mem_ready),
    .expired (expired)
  );

  // State register
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words == '0) state_d = FIN;
          else if (fill_start) state_d = WR;
          else                 state_d = RD;
        end
      end
      RD: begin
        if (expired) state_d = FIN;
        else if (hs) state_d = WR;
      end
      WR: begin
        if (expired)        state_d = FIN;
        else if (hs) begin
          if (last_word)    state_d = FIN;
          else if (fill_q)  state_d = WR;
          else              state_d = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs. mem_valid is gated by armed_q, which is low for the first
  // cycle in RD/WR and for the cycle after any handshake or timeout, giving
  // the responder its re-arm gap. Address and data only depend on
  // registered state, so they hold while the request waits.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = WSTRB_READ;
    case (state_q)
      RD: begin
        mem_valid = armed_q;
        mem_addr  = src_q + word_off;
      end
      WR: begin
        mem_valid = armed_q;
        mem_addr  = dst_q + word_off;
        mem_wdata = data_q;
        mem_wstrb = WSTRB_WORD;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = cnt_q;

  // Job registers and datapath
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      data_q  <= 32'h0;
      len_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      armed_q <= ((state_q == RD) || (state_q == WR)) && !hs && !expired;
      done_q  <= (state_q == FIN);
      if (accept) begin
        src_q   <= src_addr & 32'hFFFF_FFFC;
        dst_q   <= dst_addr & 32'hFFFF_FFFC;
        len_q   <= len_words;
        cnt_q   <= '0;
        error_q <= 1'b0;
        fill_q  <= fill_start;
        data_q  <= fill_word;
      end
      if ((state_q == RD) && hs) data_q <= mem_rdata;
      if ((state_q == WR) && hs) cnt_q  <= cnt_q + LEN_W'(1);
      if (expired)               error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_dma.sv
`timescale 1ns/1ps
// tb_mem_bus_dma
// Randomised bench for mem_bus_dma: a memory responder with random wait
// states, a sequential word-copy/fill reference model, and directed jobs
// for zero length, timeout, address wrap, alignment and ignored starts.
module tb_mem_bus_dma;

  logic        cpu_clk    = 1'b0;
  logic        reset      = 1'b0;
  logic        start      = 1'b0;
  logic [31:0] src_addr   = 32'h0;
  logic [31:0] dst_addr   = 32'h0;
  logic [15:0] len_words  = 16'h0;
  logic        fill_mode  = 1'b0;
  logic [31:0] fill_value = 32'h0;
  logic        mem_ready  = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        busy, done, error, mem_valid;
  logic [15:0] words_done;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  mem_bus_dma #(.LEN_W(16), .TIMEOUT_CYCLES(255)) dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } op_t;

  op_t         obs_q[$];
  op_t         exp_q[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // ---------------- responder ----------------
  bit          never_ready = 1'b0;
  int          max_lat     = 0;
  int          wait_left   = 0;
  int          stall_run   = 0;
  int          max_stall   = 0;
  bit          in_txn      = 1'b0;
  logic        prev_valid  = 1'b0;
  logic        prev_ready  = 1'b0;
  logic [31:0] prev_addr   = 32'h0;
  logic [31:0] prev_wdata  = 32'h0;
  logic [3:0]  prev_strb   = 4'h0;

  always @(negedge cpu_clk) begin
    if (reset) begin
      mem_ready  = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      in_txn     = 1'b0;
      stall_run  = 0;
    end else begin
      if (prev_valid && prev_ready) begin
        check_eq("rearm_gap", 32'(mem_valid), 32'h0);
      end else if (prev_valid && mem_valid) begin
        check_eq("hold_addr", mem_addr, prev_addr);
        check_eq("hold_wdata", mem_wdata, prev_wdata);
        check_eq("hold_wstrb", 32'(mem_wstrb), 32'(prev_strb));
      end
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          wait_left = int'($urandom_range(0, 32'(max_lat)));
          stall_run = 0;
        end
        if (!never_ready && wait_left == 0) begin
          mem_ready = 1'b1;
          in_txn    = 1'b0;
          if (mem_wstrb == 4'hF) begin
            bus_mem[mem_addr] = mem_wdata;
            obs_q.push_back(op_t'{addr: mem_addr, strb: mem_wstrb, data: mem_wdata});
          end else begin
            mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_word(mem_addr);
            obs_q.push_back(op_t'{addr: mem_addr, strb: mem_wstrb, data: mem_rdata});
          end
        end else begin
          wait_left--;
          stall_run++;
          if (stall_run > max_stall) max_stall = stall_run;
        end
      end else begin
        in_txn = 1'b0;
      end
      prev_valid = mem_valid;
      prev_ready = mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_strb  = mem_wstrb;
    end
  end

  // ---------------- reference model ----------------
  // Each job is a sequence of word moves; copy reads the current source
  // word (earlier writes of the same job included), fill uses the constant.
  task automatic build_expected(input logic [31:0] s, input logic [31:0] d, input int len,
                                input bit fm, input logic [31:0] fv);
    logic [31:0] sa, da, ra, wa, w;
    bit          eff_fill;
`ifdef DMA_FILL_EN
    eff_fill = fm;
`else
    eff_fill = 1'b0;
`endif
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      if (eff_fill) begin
        w = fv;
      end else begin
        w = mdl_mem.exists(ra) ? mdl_mem[ra] : init_word(ra);
        exp_q.push_back(op_t'{addr: ra, strb: 4'h0, data: w});
      end
      exp_q.push_back(op_t'{addr: wa, strb: 4'hF, data: w});
      mdl_mem[wa] = w;
    end
  endtask

  int job_no = 0;

  task automatic run_job(input string name, input logic [31:0] s, input logic [31:0] d,
                         input int len, input bit fm, input logic [31:0] fv,
                         input bit expect_to, input int pulse_at);
    int cyc, done_cnt, done_cyc, n;
    bit busy1, saw_valid;
    if (!expect_to) build_expected(s, d, len, fm, fv);
    else exp_q.delete();
    obs_q.delete();
    max_stall = 0;
    @(negedge cpu_clk);
    src_addr   = s;
    dst_addr   = d;
    len_words  = 16'(len);
    fill_mode  = fm;
    fill_value = fv;
    start      = 1'b1;
    @(negedge cpu_clk);
    start      = 1'b0;
    // Scramble the inputs: the job must run from its latched copies.
    src_addr   = $urandom;
    dst_addr   = $urandom;
    len_words  = 16'($urandom_range(1, 9));
    fill_mode  = 1'($urandom);
    fill_value = $urandom;
    cyc = 1; done_cnt = 0; done_cyc = 0; saw_valid = 1'b0;
    busy1 = busy;
    while (cyc <= 3000) begin
      if (mem_valid) saw_valid = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc > done_cyc) break;
      start = (cyc == pulse_at);
      @(negedge cpu_clk);
      cyc++;
    end
    start = 1'b0;
    check_eq({name, " busy_after_start"}, 32'(busy1), 32'h1);
    check_eq({name, " done_seen"}, 32'(done_cyc != 0), 32'h1);
    check_eq({name, " done_pulses"}, 32'(done_cnt), 32'h1);
    check_eq({name, " busy_after_done"}, 32'(busy), 32'h0);
    check_eq({name, " error"}, 32'(error), 32'(expect_to));
    check_eq({name, " words_done"}, 32'(words_done), expect_to ? 32'h0 : 32'(len));
    check_eq({name, " valid_idle"}, 32'(mem_valid), 32'h0);
    check_eq({name, " op_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s op%0d addr", name, i), obs_q[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s op%0d strb", name, i), 32'(obs_q[i].strb), 32'(exp_q[i].strb));
      check_eq($sformatf("%s op%0d data", name, i), obs_q[i].data, exp_q[i].data);
    end
    if (len == 0) begin
      check_eq({name, " len0_done_cycle"}, 32'(done_cyc), 32'd2);
      check_eq({name, " len0_no_valid"}, 32'(saw_valid), 32'h0);
    end
    if (expect_to) begin
      check_eq({name, " wait_cycles"}, 32'(max_stall), 32'd255);
    end
    $display("job %0d %s src=%h dst=%h len=%0d fill=%0b ops=%0d done_cyc=%0d err=%0b words=%0d",
             job_no, name, s, d, len, fm, obs_q.size(), done_cyc, error, words_done);
    job_no++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"}, 32'(busy), 32'h0);
    check_eq({tag, " done"}, 32'(done), 32'h0);
    check_eq({tag, " error"}, 32'(error), 32'h0);
    check_eq({tag, " words_done"}, 32'(words_done), 32'h0);
    check_eq({tag, " mem_valid"}, 32'(mem_valid), 32'h0);
    check_eq({tag, " mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, " mem_wdata"}, mem_wdata, 32'h0);
    check_eq({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'h0);
  endtask

  initial begin
    bit seen_done;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge cpu_clk);
    reset = 1'b0;

    // Basic copy with a single-cycle responder.
    max_lat = 0;
    run_job("copy3", 32'h100, 32'h200, 3, 1'b0, 32'h0, 1'b0, 0);

    // Reset while idle clears the retained word count.
    @(negedge cpu_clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("idle_reset");
    @(negedge cpu_clk);
    reset = 1'b0;

    run_job("len0", 32'h100, 32'h200, 0, 1'b0, 32'h0, 1'b0, 0);

    never_ready = 1'b1;
    run_job("timeout", 32'h180, 32'h280, 2, 1'b0, 32'h0, 1'b1, 0);
    never_ready = 1'b0;

    max_lat = 2;
    run_job("wrap", 32'hFFFF_FFFC, 32'h300, 2, 1'b0, 32'h0, 1'b0, 0);
    run_job("unaligned", 32'h103, 32'h341, 1, 1'b0, 32'h0, 1'b0, 0);
    run_job("start_ignored", 32'h120, 32'h220, 4, 1'b0, 32'h0, 1'b0, 3);
    run_job("fill4", 32'h500, 32'h400, 4, 1'b1, 32'hA5A5_A5A5, 1'b0, 0);

    // Reset in the middle of a stalled job: outputs clear at once, no done.
    never_ready = 1'b1;
    @(negedge cpu_clk);
    src_addr = 32'h600; dst_addr = 32'h700; len_words = 16'd4; fill_mode = 1'b0;
    start = 1'b1;
    @(negedge cpu_clk);
    start = 1'b0;
    repeat (5) @(negedge cpu_clk);
    check_eq("pre_reset busy", 32'(busy), 32'h1);
    check_eq("pre_reset mem_valid", 32'(mem_valid), 32'h1);
    @(posedge cpu_clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort_reset");
    @(negedge cpu_clk);
    reset = 1'b0;
    never_ready = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge cpu_clk);
      if (done) seen_done = 1'b1;
    end
    check_eq("abort no_done", 32'(seen_done), 32'h0);

    // Random jobs over a small, overlapping address window.
    for (int k = 0; k < 25; k++) begin
      logic [31:0] s, d;
      max_lat = int'($urandom_range(0, 3));
      s = 32'h1000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      d = 32'h1000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      run_job($sformatf("rand%0d", k), s, d, int'($urandom_range(0, 6)),
              1'($urandom), $urandom, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_dma.md
MEM_BUS_DMA -- requirements
Module: mem_bus_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of length and progress counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait for mem_ready per transaction.
REQ-003 SHALL have port cpu_clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle job request.
REQ-006 SHALL have port src_addr  in  32  source byte address, latched at start.
REQ-007 SHALL have port dst_addr  in  32  destination byte address, latched at start.
REQ-008 SHALL have port len_words  in  LEN_W  word count, latched at start.
REQ-009 SHALL have port fill_mode  in  1  fill instead of copy (used only with DMA_FILL_EN).
REQ-010 SHALL have port fill_value  in  32  fill word, latched at start (used only with DMA_FILL_EN).
REQ-011 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port error  out  1  timeout flag, sticky until next accepted start.
REQ-014 SHALL have port words_done  out  LEN_W  count of completed word writes.
REQ-015 SHALL have initiator ports mem_valid out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_ready in 1, mem_rdata in 32 (picorv32 native bus).

Function
REQ-016 SHALL implement states IDLE, RD, WR, FIN.
REQ-017 SHALL accept start only in IDLE; start in any other state ignored.
REQ-018 SHALL force address bits [1:0] to 0 when latching src_addr/dst_addr.
REQ-019 SHALL go IDLE->FIN on start with len_words=0, issuing no bus traffic.
REQ-020 SHALL go IDLE->RD otherwise; RD drives mem_valid=1, mem_addr=src+4*i, mem_wstrb=0.
REQ-021 SHALL capture mem_rdata on the edge where mem_valid&&mem_ready in RD, then enter WR.
REQ-022 SHALL in WR drive mem_valid=1, mem_addr=dst+4*i, mem_wdata=captured word, mem_wstrb=4'hF.
REQ-023 SHALL on WR handshake increment i and words_done; go FIN if i==len_words, else RD.
REQ-024 SHALL hold mem_addr/mem_wdata/mem_wstrb stable while mem_valid=1 and mem_ready=0.
REQ-025 SHALL deassert mem_valid for at least one cycle after every handshake (responder re-arm).
REQ-026 SHALL wrap address arithmetic modulo 2^32.
REQ-027 SHALL count cycles with mem_valid=1, mem_ready=0; at TIMEOUT_CYCLES drop mem_valid, set error, go FIN.
REQ-028 SHALL in FIN pulse done for exactly one cycle, then return to IDLE.
REQ-029 SHALL keep words_done valid after FIN until next accepted start clears it.

Reset
REQ-030 SHALL on reset, regardless of clock, enter IDLE with mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, words_done=0.
REQ-031 SHALL abandon any in-flight transaction on reset without a done pulse.

Configuration
REQ-032 SHALL with DMA_FILL_EN defined and fill_mode=1 at start skip RD, writing fill_value to each destination word.
REQ-033 SHALL without DMA_FILL_EN ignore fill_mode/fill_value and always copy.

Structure
REQ-034 SHALL place state encoding, WSTRB_WORD=4'hF and WSTRB_READ=4'h0 in shared package mem_bus_pkg.
REQ-035 SHALL implement the timeout counter as sub-module mem_bus_timeout (clear, enable, expired).

Verification
REQ-036 SHALL cover copy: src=0x100, dst=0x200, len=3, 1-cycle responder -> 3 reads then 3 writes alternating, words at 0x200..0x208 match source, one done, words_done=3.
REQ-037 SHALL cover len=0 -> done one cycle after busy rises, mem_valid never asserted.
REQ-038 SHALL cover responder never ready -> error=1 after 255 wait cycles, mem_valid low, done pulses.
REQ-039 SHALL cover src=0xFFFFFFFC, len=2 -> second read at 0x00000000; src=0x103 latched as 0x100.
REQ-040 SHALL cover start pulsed while busy -> ignored, job completes with original parameters.
REQ-041 SHALL cover DMA_FILL_EN, fill_mode=1, fill_value=0xA5A5A5A5, len=4 -> 4 writes only, no reads.
